// File: rtl/fp_class_pkg.sv
// Shared constants for the FP operand classifier: CLASS.fmt bit positions
// and IEEE-754 field widths per operand width.
package fp_class_pkg;

    localparam int CLASS_W = 10;

    localparam int CLS_SNAN  = 0;
    localparam int CLS_QNAN  = 1;
    localparam int CLS_NINF  = 2;
    localparam int CLS_NNORM = 3;
    localparam int CLS_NSUB  = 4;
    localparam int CLS_NZERO = 5;
    localparam int CLS_PINF  = 6;
    localparam int CLS_PNORM = 7;
    localparam int CLS_PSUB  = 8;
    localparam int CLS_PZERO = 9;

    function automatic int fp_frac_w(input int w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int fp_exp_w(input int w);
        return (w == 64) ? 11 : 8;
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational decode of one IEEE-754 operand into the one-hot
// MIPS R6 CLASS.fmt encoding.
module fp_class_decode
    import fp_class_pkg::*;
#(
    parameter int W = 32
)
(
    input  logic [W-1:0]       op,
    output logic [CLASS_W-1:0] cls
);
    localparam int FW = fp_frac_w(W);
    localparam int EW = fp_exp_w(W);

    logic          sign;
    logic [EW-1:0] exp_f;
    logic [FW-1:0] mant;

    assign sign  = op[W-1];
    assign exp_f = op[W-2:FW];
    assign mant  = op[FW-1:0];

    // NaN classes carry no sign; the quiet bit is the fraction MSB.
    always_comb begin
        cls = '0;
        if (&exp_f) begin
            if (mant == '0)
                cls[sign ? CLS_NINF : CLS_PINF] = 1'b1;
            else if (mant[FW-1])
                cls[CLS_QNAN] = 1'b1;
            else
                cls[CLS_SNAN] = 1'b1;
        end else if (exp_f == '0) begin
            if (mant == '0)
                cls[sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
            else
                cls[sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
        end else begin
            cls[sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_operand_classifier.sv
// Two-stage elastic pipeline classifying NUM_SRC FP operands per transaction,
// with NaN summaries and a sticky invalid-operation flag for FCSR.
module fp_operand_classifier
    import fp_class_pkg::*;
#(
    parameter int W       = 32,
    parameter int NUM_SRC = 2,
    parameter int TAG_W   = 6
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_SRC*W-1:0]         in_ops,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_SRC*CLASS_W-1:0]   out_class,
    output logic                         out_any_nan,
    output logic                         out_any_snan,
    output logic [TAG_W-1:0]             out_tag,
    input  logic                         clear_sticky,
    output logic                         sticky_invalid
);
    if (!(W == 32 || W == 64)) begin : g_bad_w
        $error("fp_operand_classifier: W must be 32 or 64");
    end
    if (NUM_SRC < 1 || NUM_SRC > 3) begin : g_bad_num_src
        $error("fp_operand_classifier: NUM_SRC must be 1..3");
    end

    logic                       s1_valid;
    logic [NUM_SRC*W-1:0]       s1_ops;
    logic [TAG_W-1:0]           s1_tag;
    logic                       s2_valid;
    logic [NUM_SRC*CLASS_W-1:0] s2_class;
    logic                       s2_nan;
    logic                       s2_snan;
    logic [TAG_W-1:0]           s2_tag;
    logic                       s1_load;
    logic                       s2_load;
    logic [NUM_SRC*CLASS_W-1:0] dec_class;
    logic                       any_nan_c;
    logic                       any_snan_c;
    logic                       sticky_q;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_dec
        fp_class_decode #(.W(W)) u_dec (
            .op  (s1_ops[i*W +: W]),
            .cls (dec_class[i*CLASS_W +: CLASS_W])
        );
    end

    always_comb begin
        any_nan_c  = 1'b0;
        any_snan_c = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            any_nan_c  = any_nan_c | dec_class[i*CLASS_W + CLS_SNAN]
                                   | dec_class[i*CLASS_W + CLS_QNAN];
            any_snan_c = any_snan_c | dec_class[i*CLASS_W + CLS_SNAN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load)
                s1_valid <= in_valid;
            if (s2_load)
                s2_valid <= s1_valid;
        end
    end

    // Payload registers need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_ops <= in_ops;
            s1_tag <= in_tag;
        end
        if (s2_load && s1_valid) begin
            s2_class <= dec_class;
            s2_nan   <= any_nan_c;
            s2_snan  <= any_snan_c;
            s2_tag   <= s1_tag;
        end
    end

    // Only delivered results set the flag; a same-cycle set beats clear.
    always_ff @(posedge clk) begin
        if (reset)
            sticky_q <= 1'b0;
        else
            sticky_q <= (sticky_q && !clear_sticky) ||
                        (s2_valid && out_ready && s2_snan);
    end

    assign out_valid      = s2_valid;
    assign out_class      = s2_class;
    assign out_any_nan    = s2_nan;
    assign out_any_snan   = s2_snan;
    assign out_tag        = s2_tag;
    assign sticky_invalid = sticky_q;

endmodule

// File: tb/tb_fp_operand_classifier.sv
// Directed bench for fp_operand_classifier: single-precision 3-operand
// instance plus a double-precision 1-operand instance.
module tb_fp_operand_classifier;

    typedef struct {
        logic [95:0] ops;
        logic [29:0] cls;
        logic        nan;
        logic        snan;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_ops;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_class;
    logic        out_any_nan;
    logic        out_any_snan;
    logic [5:0]  out_tag;
    logic        clear_sticky;
    logic        sticky_invalid;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [63:0] b_in_ops;
    logic [5:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [9:0]  b_out_class;
    logic        b_out_any_nan;
    logic        b_out_any_snan;
    logic [5:0]  b_out_tag;
    logic        b_clear_sticky;
    logic        b_sticky_invalid;

    int n_checks = 0;
    int n_errors = 0;
    logic model_sticky = 1'b0;
    vec_t tbl [6];
    logic [63:0] b_ops [5];
    logic [9:0]  b_cls [5];

    fp_operand_classifier #(.W(32), .NUM_SRC(3), .TAG_W(6)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ops         (in_ops),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_class      (out_class),
        .out_any_nan    (out_any_nan),
        .out_any_snan   (out_any_snan),
        .out_tag        (out_tag),
        .clear_sticky   (clear_sticky),
        .sticky_invalid (sticky_invalid)
    );

    fp_operand_classifier #(.W(64), .NUM_SRC(1), .TAG_W(6)) u_dut_d (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (b_in_valid),
        .in_ready       (b_in_ready),
        .in_ops         (b_in_ops),
        .in_tag         (b_in_tag),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_class      (b_out_class),
        .out_any_nan    (b_out_any_nan),
        .out_any_snan   (b_out_any_snan),
        .out_tag        (b_out_tag),
        .clear_sticky   (b_clear_sticky),
        .sticky_invalid (b_sticky_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [5:0] tag, input int idx);
        @(posedge clk); #1;
        in_valid = 1'b1; in_ops = v.ops; in_tag = tag; out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_accept", idx), 64'(in_ready), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_lat1_valid", idx), 64'(out_valid), 64'(1'b0));
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_lat2_valid", idx), 64'(out_valid), 64'(1'b1));
        chk($sformatf("v%0d_class", idx), 64'(out_class), 64'(v.cls));
        chk($sformatf("v%0d_any_nan", idx), 64'(out_any_nan), 64'(v.nan));
        chk($sformatf("v%0d_any_snan", idx), 64'(out_any_snan), 64'(v.snan));
        chk($sformatf("v%0d_tag", idx), 64'(out_tag), 64'(tag));
        model_sticky = model_sticky | v.snan;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_sticky", idx), 64'(sticky_invalid), 64'(model_sticky));
        chk($sformatf("v%0d_drained", idx), 64'(out_valid), 64'(1'b0));
    endtask

    function automatic logic [95:0] stream_ops(input int t);
        logic [31:0] op0, op1;
        op0 = t[0] ? 32'hBF800000 : 32'h3F800000;
        op1 = t[1] ? 32'h00000005 : 32'h00000000;
        return {32'h80000000, op1, op0};
    endfunction

    function automatic logic [29:0] stream_cls(input int t);
        logic [9:0] c0, c1;
        c0 = t[0] ? 10'h008 : 10'h080;
        c1 = t[1] ? 10'h100 : 10'h200;
        return {10'h020, c1, c0};
    endfunction

    initial begin
        logic [3:0] pat;
        int sent, rcv, cnt;
        logic fire_in, fire_out;

        tbl[0] = '{{32'h3F800000, 32'h00000000, 32'h80000001}, {10'h080, 10'h200, 10'h010}, 1'b0, 1'b0};
        tbl[1] = '{{32'hFF800000, 32'h7FC00000, 32'h7F800001}, {10'h004, 10'h002, 10'h001}, 1'b1, 1'b1};
        tbl[2] = '{{32'h80000000, 32'h00400000, 32'h7F800000}, {10'h020, 10'h100, 10'h040}, 1'b0, 1'b0};
        tbl[3] = '{{32'h00000001, 32'h3F800000, 32'hFFC00001}, {10'h100, 10'h080, 10'h002}, 1'b1, 1'b0};
        tbl[4] = '{{32'h807FFFFF, 32'hFF7FFFFF, 32'h7FBFFFFF}, {10'h010, 10'h008, 10'h001}, 1'b1, 1'b1};
        tbl[5] = '{{32'h7F7FFFFF, 32'h00800000, 32'hFFFFFFFF}, {10'h080, 10'h080, 10'h002}, 1'b1, 1'b0};

        b_ops[0] = 64'h7FF8000000000000; b_cls[0] = 10'h002;
        b_ops[1] = 64'hFFF0000000000000; b_cls[1] = 10'h004;
        b_ops[2] = 64'h0000000000000001; b_cls[2] = 10'h100;
        b_ops[3] = 64'h8000000000000000; b_cls[3] = 10'h020;
        b_ops[4] = 64'h7FF4000000000000; b_cls[4] = 10'h001;

        reset = 1'b1;
        in_valid = 1'b0; in_ops = '0; in_tag = '0; out_ready = 1'b1; clear_sticky = 1'b0;
        b_in_valid = 1'b0; b_in_ops = '0; b_in_tag = '0; b_out_ready = 1'b1; b_clear_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_sticky", 64'(sticky_invalid), 64'(1'b0));

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], 6'(i + 1), i);

        // double-precision instance, one operand per transaction
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1; b_in_ops = b_ops[i]; b_in_tag = 6'(i + 10);
            @(negedge clk);
            chk($sformatf("d%0d_accept", i), 64'(b_in_ready), 64'(1'b1));
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("d%0d_valid", i), 64'(b_out_valid), 64'(1'b1));
            chk($sformatf("d%0d_class", i), 64'(b_out_class), 64'(b_cls[i]));
            chk($sformatf("d%0d_any_nan", i), 64'(b_out_any_nan), 64'(b_cls[i][0] | b_cls[i][1]));
            chk($sformatf("d%0d_tag", i), 64'(b_out_tag), 64'(i + 10));
        end
        @(posedge clk);
        @(negedge clk);
        chk("d_sticky", 64'(b_sticky_invalid), 64'(1'b1));

        // back-to-back stream under toggling backpressure
        pat = 4'b1001;
        sent = 0; rcv = 0;
        for (int c = 0; c < 200 && rcv < 8; c++) begin
            @(posedge clk); #1;
            out_ready = pat[2'(c)];
            if (sent < 8) begin
                in_valid = 1'b1; in_tag = 6'(sent); in_ops = stream_ops(sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cnt = sent - rcv;
            chk($sformatf("s_c%0d_in_ready", c), 64'(in_ready), 64'((cnt < 2) || out_ready));
            if (cnt == 2)
                chk($sformatf("s_c%0d_full_valid", c), 64'(out_valid), 64'(1'b1));
            if (out_valid) begin
                chk($sformatf("s_c%0d_tag", c), 64'(out_tag), 64'(rcv));
                chk($sformatf("s_c%0d_class", c), 64'(out_class), 64'(stream_cls(rcv)));
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) rcv++;
            if (fire_in) sent++;
        end
        chk("s_all_delivered", 64'(rcv), 64'(8));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("s_sticky_clean", 64'(sticky_invalid), 64'(model_sticky));

        // clear and set in the same cycle: set wins
        chk("clr_pre", 64'(sticky_invalid), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b1; in_ops = tbl[1].ops; in_tag = 6'h09;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear_sticky = 1'b1;
        @(negedge clk);
        chk("clr_deliver_valid", 64'(out_valid), 64'(1'b1));
        chk("clr_deliver_snan", 64'(out_any_snan), 64'(1'b1));
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_set_wins", 64'(sticky_invalid), 64'(1'b1));
        @(posedge clk); #1;
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_alone", 64'(sticky_invalid), 64'(1'b0));
        model_sticky = 1'b0;

        // reset with two transactions in flight
        run_vec(tbl[4], 6'h20, 6);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_ops = tbl[1].ops; in_tag = 6'h21;
        @(posedge clk); #1;
        in_tag = 6'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_full_valid", 64'(out_valid), 64'(1'b1));
        chk("rst_mid_full_in_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_mid_hold_tag", 64'(out_tag), 64'(6'h21));
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1; in_tag = 6'h3F; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_mid_sticky", 64'(sticky_invalid), 64'(1'b0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(1'b1));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rst_no_stale_%0d", c), 64'(out_valid), 64'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_operand_classifier.md
# fp_operand_classifier

Pipelined, parametrised IEEE-754 operand classifier for the FPU issue path. Classifies up to three source operands per transaction into the 10-bit MIPS R6 CLASS.fmt one-hot encoding, distinguishes signalling from quiet NaN, and separates subnormal from zero. Sits between FP register read and the FP execution units behind a valid/ready handshake. Keeps a sticky invalid-operation flag for FCSR update.

## Interface
- W, 32: operand width; only 32 (single) and 64 (double) are legal
- NUM_SRC, 2: operands per transaction, 1..3 (3 for madd/msub)
- TAG_W, 6: width of the opaque tag carried alongside each transaction

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid && in_ready
- in_ops  in  NUM_SRC*W  operand i at [i*W +: W]
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_class  out  NUM_SRC*10  operand i class at [i*10 +: 10]
- out_any_nan  out  1  any operand is NaN (signalling or quiet)
- out_any_snan  out  1  any operand is a signalling NaN
- out_tag  out  TAG_W  tag of the result
- clear_sticky  in  1  clear the sticky invalid flag
- sticky_invalid  out  1  set once any delivered result had out_any_snan

## Operation
- Field split: FW = 23/52, EW = 8/11; sign = bit W-1, exp = [W-2:FW], mant = [FW-1:0].
- Class bits, exactly one set per operand:
  - bit0 SNaN: exp all-ones, mant != 0, mant[FW-1] = 0
  - bit1 QNaN: exp all-ones, mant[FW-1] = 1
  - bit2/6 -inf/+inf: exp all-ones, mant = 0
  - bit3/7 -/+normal: exp neither 0 nor all-ones
  - bit4/8 -/+subnormal: exp 0, mant != 0
  - bit5/9 -/+zero: exp 0, mant 0
- NaN classes ignore the sign bit.
- out_any_nan = OR of bits 0,1 over all operands; out_any_snan = OR of bit0 over all operands.
- Sticky register:
  - Next value = (sticky && !clear_sticky) || (out_valid && out_ready && out_any_snan).
  - When clear and set occur in the same cycle, set wins.
  - Results stalled in the pipe do not set the flag.

## Timing
- Two-stage elastic pipeline:
  - S1 registers ops and tag.
  - S2 registers class, NaN summaries and tag.
- Latency: a transaction accepted in cycle N appears on out_valid in cycle N+2 when there is no backpressure.
- Throughput: one transaction per cycle.
- Stage advance rules:
  - S2 loads when it is empty or out_ready = 1.
  - S1 loads when it is empty or S2 loads that cycle.
  - in_ready = !s1_valid || s2_load. It is combinational from out_ready. This is permitted, and downstream must not depend combinationally on in_ready.
- Backpressure:
  - With out_ready = 0 and both stages full, in_ready = 0.
  - out_* hold stable while out_valid && !out_ready.
- No transaction is dropped or duplicated.
- Reset:
  - Clears s1_valid, s2_valid and sticky_invalid to 0.
  - Data and tag registers are don't-care after reset, and out_class/out_tag are undefined while out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight transactions. A handshake that coincides with reset is ignored.
- W outside {32,64} or NUM_SRC outside 1..3 is a compile-time error via a generate-time check.

## Structure
- Package fp_class_pkg holds:
  - class bit index constants (CLS_SNAN .. CLS_PZERO)
  - the CLASS_W = 10 localparam
  - functions returning FW and EW for a given W
- Sub-module fp_class_decode (W parameter): purely combinational, one operand to a 10-bit class. Instantiated NUM_SRC times in a generate loop feeding S2.
- Pipeline control and the sticky register live in the top module.

## Test plan
- W=32, NUM_SRC=3, ops {0x7F800001, 0x7FC00000, 0xFF800000} -> out_class {0x001, 0x002, 0x004}; out_any_nan = 1; out_any_snan = 1; result 2 cycles after accept; sticky_invalid = 1 the cycle after delivery.
- W=32, ops {0x80000001, 0x00000000, 0x3F800000} -> {0x010, 0x200, 0x080}; both NaN flags 0. W=64, op 0x7FF8000000000000 -> 0x002; 0xFFF0000000000000 -> 0x004.
- Back-to-back stream of 8 tags 0..7 with out_ready toggling 1,0,0,1 -> all 8 tags delivered in order, none lost. in_ready = 0 whenever both stages are full and out_ready = 0. Outputs stable during stall.
- sticky_invalid = 1; assert clear_sticky while delivering a SNaN result -> sticky stays 1. Clear alone next cycle -> 0.
- Assert reset with two transactions in flight -> out_valid = 0 and sticky_invalid = 0 next cycle; in_ready = 1. No stale tag is ever delivered.
